// File: rtl/fft_result_writer.sv
// Drains the FFT result SRAM to system memory over an Avalon-MM write master.
// Define FFT_WRITER_PACK_EN to pack {imag, real} pairs into one write each.
module fft_result_writer #(
   parameter int MASTER_ADDRESSWIDTH = 32,
   parameter int DATAWIDTH           = 32,
   parameter int SRAM_ADDRWIDTH      = 9,
   parameter int NUM_WORDS           = 512
) (
   input  logic                           clk,
   input  logic                           n_rst,
   input  logic                           start,
   input  logic [MASTER_ADDRESSWIDTH-1:0] base_address,
   output logic                           f_rden,
   output logic [SRAM_ADDRWIDTH-1:0]      f_address,
   input  logic [15:0]                    f_q,
   output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
   output logic [DATAWIDTH-1:0]           master_writedata,
   output logic                           master_write,
   input  logic                           master_waitrequest,
   output logic                           busy,
   output logic                           done
);

   typedef enum logic [2:0] {
      IDLE, RD, CAP, WR, DONE
`ifdef FFT_WRITER_PACK_EN
      , RD2
`endif
   } state_t;

`ifdef FFT_WRITER_PACK_EN
   localparam int LAST_I = NUM_WORDS / 2 - 1;
   localparam logic [SRAM_ADDRWIDTH-1:0] HALF_A =
      SRAM_ADDRWIDTH'(NUM_WORDS / 2);
`else
   localparam int LAST_I = NUM_WORDS - 1;
   localparam int EXT = DATAWIDTH - 16;
`endif
   localparam logic [SRAM_ADDRWIDTH-1:0] LAST =
      SRAM_ADDRWIDTH'(LAST_I);

   state_t state, state_n;

   logic [MASTER_ADDRESSWIDTH-1:0] base_q;
   logic [SRAM_ADDRWIDTH-1:0]      idx;
   logic [DATAWIDTH-1:0]           data_q;
   logic [MASTER_ADDRESSWIDTH-1:0] wr_off;
   logic                           accept;
   logic                           is_last;

   assign wr_off  = MASTER_ADDRESSWIDTH'({idx, 2'b00});
   assign accept  = (state == WR) && !master_waitrequest;
   assign is_last = (idx == LAST);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n          = state;
      f_rden           = 1'b0;
      f_address        = '0;
      master_write     = 1'b0;
      master_address   = '0;
      master_writedata = '0;
      busy             = 1'b1;
      done             = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_n = RD;
         end
         RD: begin
            f_rden    = 1'b1;
            f_address = idx;
`ifdef FFT_WRITER_PACK_EN
            state_n   = RD2;
`else
            state_n   = CAP;
`endif
         end
`ifdef FFT_WRITER_PACK_EN
         RD2: begin
            f_rden    = 1'b1;
            f_address = idx + HALF_A;
            state_n   = CAP;
         end
`endif
         CAP: state_n = WR;
         WR: begin
            master_write     = 1'b1;
            master_address   = base_q + wr_off;
            master_writedata = data_q;
            if (!master_waitrequest) state_n = is_last ? DONE : RD;
         end
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         base_q <= '0;
         idx    <= '0;
         data_q <= '0;
      end else begin
         if (state == IDLE && start) begin
            base_q <= base_address;
            idx    <= '0;
         end
         if (accept && !is_last) idx <= idx + SRAM_ADDRWIDTH'(1);
`ifdef FFT_WRITER_PACK_EN
         // Real part arrives during RD2, imaginary part during CAP.
         if (state == RD2) data_q <= DATAWIDTH'(f_q);
         if (state == CAP) data_q[31:16] <= f_q;
`else
         if (state == CAP) data_q <= {{EXT{f_q[15]}}, f_q};
`endif
      end
   end

endmodule

// File: tb/tb_fft_result_writer.sv
// Self-checking bench for fft_result_writer: SRAM and Avalon slave models,
// randomized contents and stalls, checked against a per-word reference model.
module tb_fft_result_writer;

   localparam int NSRAM = 512;
`ifdef FFT_WRITER_PACK_EN
   localparam bit PACK = 1'b1;
`else
   localparam bit PACK = 1'b0;
`endif
   localparam int NWR   = PACK ? 256 : 512;
   localparam int CPW   = PACK ? 4 : 3;
   localparam int LIMIT = 6000;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        start;
   logic [31:0] base_address;
   logic        f_rden;
   logic [8:0]  f_address;
   logic [15:0] f_q;
   logic [31:0] master_address;
   logic [31:0] master_writedata;
   logic        master_write;
   logic        master_waitrequest;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   fft_result_writer dut (
      .clk                (clk),
      .n_rst              (n_rst),
      .start              (start),
      .base_address       (base_address),
      .f_rden             (f_rden),
      .f_address          (f_address),
      .f_q                (f_q),
      .master_address     (master_address),
      .master_writedata   (master_writedata),
      .master_write       (master_write),
      .master_waitrequest (master_waitrequest),
      .busy               (busy),
      .done               (done)
   );

   logic [15:0] mem [NSRAM];

   always @(posedge clk) if (f_rden) f_q <= mem[f_address];

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] wr_addr [$];
   logic [31:0] wr_data [$];
   int   done_cnt, done_at, unstable, leak, stalls;
   bit   timed_out;
   logic busy_first, busy_after;

   function automatic logic [31:0] exp_data(input int i);
      int j;
      j = (i + 256) % NSRAM;
      return PACK ? {mem[j], mem[i]} : {{16{mem[i][15]}}, mem[i]};
   endfunction

   function automatic logic [31:0] exp_addr(input logic [31:0] b,
                                            input int i);
      return b + 32'(4 * i);
   endfunction

   task automatic load_ramp();
      for (int i = 0; i < NSRAM; i++) mem[i] = (i < 256) ? 16'(i) : 16'h0;
   endtask

   task automatic load_rand();
      for (int i = 0; i < NSRAM; i++) mem[i] = 16'($urandom);
   endtask

   // Drives one transfer and records what the Avalon slave observed.
   // stall_mode: >=0 fixed stall cycles per write, -1 random 0..2.
   task automatic run_xfer(input logic [31:0] base, input int stall_mode,
                           input bit inject);
      int n, sl;
      bit in_wr;
      logic [31:0] ha, hd;
      wr_addr.delete();
      wr_data.delete();
      done_cnt = 0; done_at = 0; unstable = 0; leak = 0; stalls = 0;
      timed_out = 0; busy_first = 1'bx; busy_after = 1'bx;
      in_wr = 0; sl = 0; ha = '0; hd = '0;
      @(negedge clk);
      base_address = base;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (n <= LIMIT) begin
         if (n == 1) busy_first = busy;
         if (done) begin
            done_cnt++;
            if (done_cnt == 1) done_at = n;
         end
         if (done_at > 0 && n == done_at + 1) busy_after = busy;
         if (!master_write && (master_address !== 0 || master_writedata !== 0))
            leak++;
         if (!f_rden && f_address !== 0) leak++;
         if (master_write) begin
            if (!in_wr) begin
               in_wr = 1;
               sl = (stall_mode < 0) ? int'($urandom_range(0, 2)) : stall_mode;
               ha = master_address;
               hd = master_writedata;
            end else if (master_address !== ha || master_writedata !== hd) begin
               unstable++;
            end
            if (sl > 0) begin
               master_waitrequest = 1'b1;
               sl--;
               stalls++;
            end else begin
               master_waitrequest = 1'b0;
               wr_addr.push_back(master_address);
               wr_data.push_back(master_writedata);
               in_wr = 0;
            end
         end else begin
            master_waitrequest = 1'b0;
         end
         if (inject && (n == 10 || n == 700 || n == 701)) begin
            start = 1'b1;
            base_address = $urandom;
         end else begin
            start = 1'b0;
         end
         if (done_at > 0 && n >= done_at + 2) break;
         @(negedge clk);
         n++;
      end
      if (done_at == 0) timed_out = 1;
      master_waitrequest = 1'b0;
      start = 1'b0;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      start = 1'b0;
      master_waitrequest = 1'b0;
      base_address = '0;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({f_rden, f_address, master_address, master_writedata,
           master_write, busy, done} !== 77'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rden=%b fa=%h ma=%h md=%h w=%b busy=%b done=%b, expected all 0",
                  f_rden, f_address, master_address, master_writedata,
                  master_write, busy, done);
      end
      n_rst = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || master_write !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got busy=%b write=%b, expected 0 0",
                  busy, master_write);
      end
   endtask

   task automatic test_ramp_no_stall();
      load_ramp();
      run_xfer(32'h1000, 0, 0);
      n_chk++;
      if (timed_out !== 1'b0) begin
         n_fail++;
         $display("FAIL ramp_timeout: got no done, expected done");
      end
      n_chk++;
      if (wr_addr.size() !== NWR) begin
         n_fail++;
         $display("FAIL ramp_count: got %0d writes, expected %0d",
                  wr_addr.size(), NWR);
      end
      for (int k = 0; k < NWR && k < wr_addr.size(); k++) begin
         n_chk++;
         if (wr_addr[k] !== exp_addr(32'h1000, k) ||
             wr_data[k] !== exp_data(k)) begin
            n_fail++;
            $display("FAIL ramp_word %0d: got %h/%h, expected %h/%h", k,
                     wr_addr[k], wr_data[k], exp_addr(32'h1000, k),
                     exp_data(k));
         end
      end
      n_chk++;
      if (done_at !== 1 + NWR * CPW || done_cnt !== 1) begin
         n_fail++;
         $display("FAIL ramp_done: got cycle %0d count %0d, expected cycle %0d count 1",
                  done_at, done_cnt, 1 + NWR * CPW);
      end
      n_chk++;
      if (busy_first !== 1'b1 || busy_after !== 1'b0) begin
         n_fail++;
         $display("FAIL ramp_busy: got first=%b after=%b, expected 1 0",
                  busy_first, busy_after);
      end
      n_chk++;
      if (leak !== 0) begin
         n_fail++;
         $display("FAIL ramp_zero_when_idle: got %0d leaks, expected 0", leak);
      end
   endtask

   task automatic test_stall();
      load_ramp();
      run_xfer(32'h1000, 3, 0);
      n_chk++;
      if (wr_addr.size() !== NWR) begin
         n_fail++;
         $display("FAIL stall_count: got %0d writes, expected %0d",
                  wr_addr.size(), NWR);
      end
      for (int k = 0; k < NWR && k < wr_addr.size(); k++) begin
         n_chk++;
         if (wr_addr[k] !== exp_addr(32'h1000, k) ||
             wr_data[k] !== exp_data(k)) begin
            n_fail++;
            $display("FAIL stall_word %0d: got %h/%h, expected %h/%h", k,
                     wr_addr[k], wr_data[k], exp_addr(32'h1000, k),
                     exp_data(k));
         end
      end
      n_chk++;
      if (unstable !== 0) begin
         n_fail++;
         $display("FAIL stall_stable: got %0d changes, expected 0", unstable);
      end
      n_chk++;
      if (done_at !== 1 + NWR * (CPW + 3)) begin
         n_fail++;
         $display("FAIL stall_done: got cycle %0d, expected %0d",
                  done_at, 1 + NWR * (CPW + 3));
      end
   endtask

   task automatic test_sign_ext_wrap();
      logic [31:0] b;
      b = 32'hFFFF_FF80;
      load_rand();
      mem[5] = 16'h8001;
      run_xfer(b, -1, 0);
      n_chk++;
      if (wr_addr.size() !== NWR) begin
         n_fail++;
         $display("FAIL rand_count: got %0d writes, expected %0d",
                  wr_addr.size(), NWR);
      end
      for (int k = 0; k < NWR && k < wr_addr.size(); k++) begin
         n_chk++;
         if (wr_addr[k] !== exp_addr(b, k) || wr_data[k] !== exp_data(k)) begin
            n_fail++;
            $display("FAIL rand_word %0d: got %h/%h, expected %h/%h", k,
                     wr_addr[k], wr_data[k], exp_addr(b, k), exp_data(k));
         end
      end
      n_chk++;
      if (unstable !== 0 || done_at !== 1 + NWR * CPW + stalls) begin
         n_fail++;
         $display("FAIL rand_timing: got unstable=%0d done=%0d, expected 0 and %0d",
                  unstable, done_at, 1 + NWR * CPW + stalls);
      end
`ifndef FFT_WRITER_PACK_EN
      n_chk++;
      if (wr_addr.size() > 5 &&
          (wr_data[5] !== 32'hFFFF_8001 || wr_addr[5] !== b + 32'd20)) begin
         n_fail++;
         $display("FAIL sign_ext: got %h/%h, expected %h/FFFF8001",
                  wr_addr[5], wr_data[5], b + 32'd20);
      end
`endif
   endtask

   task automatic test_reset_abort();
      int acc, m;
      bit hit;
      load_rand();
      acc = 0; hit = 0;
      @(negedge clk);
      base_address = $urandom;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      master_waitrequest = 1'b0;
      for (m = 0; m < LIMIT; m++) begin
         if (master_write) begin
            if (acc == 100) begin
               hit = 1;
               break;
            end
            acc++;
         end
         @(negedge clk);
      end
      n_chk++;
      if (!hit) begin
         n_fail++;
         $display("FAIL abort_reach: got %0d writes, expected to reach write 100",
                  acc);
      end
      n_rst = 1'b0;
      #1;
      n_chk++;
      if ({f_rden, f_address, master_address, master_writedata,
           master_write, busy, done} !== 77'd0) begin
         n_fail++;
         $display("FAIL abort_outputs: got w=%b ma=%h md=%h busy=%b, expected all 0",
                  master_write, master_address, master_writedata, busy);
      end
      @(negedge clk);
      n_rst = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || master_write !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_resume: got busy=%b write=%b, expected 0 0",
                  busy, master_write);
      end
      run_xfer(32'h2000, 0, 0);
      n_chk++;
      if (wr_addr.size() !== NWR) begin
         n_fail++;
         $display("FAIL abort_rerun_count: got %0d, expected %0d",
                  wr_addr.size(), NWR);
      end
      n_chk++;
      if (wr_addr.size() > 0 &&
          (wr_addr[0] !== 32'h2000 || wr_data[0] !== exp_data(0))) begin
         n_fail++;
         $display("FAIL abort_rerun_first: got %h/%h, expected 00002000/%h",
                  wr_addr[0], wr_data[0], exp_data(0));
      end
   endtask

   task automatic test_start_while_busy();
      load_ramp();
      run_xfer(32'h3000, 0, 1);
      n_chk++;
      if (wr_addr.size() !== NWR || done_cnt !== 1) begin
         n_fail++;
         $display("FAIL busy_start_count: got %0d writes %0d done, expected %0d and 1",
                  wr_addr.size(), done_cnt, NWR);
      end
      for (int k = 0; k < NWR && k < wr_addr.size(); k++) begin
         n_chk++;
         if (wr_addr[k] !== exp_addr(32'h3000, k)) begin
            n_fail++;
            $display("FAIL busy_start_addr %0d: got %h, expected %h", k,
                     wr_addr[k], exp_addr(32'h3000, k));
         end
      end
      n_chk++;
      if (done_at !== 1 + NWR * CPW) begin
         n_fail++;
         $display("FAIL busy_start_done: got %0d, expected %0d",
                  done_at, 1 + NWR * CPW);
      end
   endtask

`ifdef FFT_WRITER_PACK_EN
   task automatic test_packed();
      load_rand();
      mem[3] = 16'h0003;
      mem[259] = 16'hFFFE;
      run_xfer(32'h4000, 0, 0);
      n_chk++;
      if (wr_addr.size() !== 256) begin
         n_fail++;
         $display("FAIL packed_count: got %0d, expected 256", wr_addr.size());
      end
      n_chk++;
      if (wr_addr.size() > 3 &&
          (wr_addr[3] !== 32'h400C || wr_data[3] !== 32'hFFFE_0003)) begin
         n_fail++;
         $display("FAIL packed_word3: got %h/%h, expected 0000400C/FFFE0003",
                  wr_addr[3], wr_data[3]);
      end
      n_chk++;
      if (done_at !== 1 + 4 * 256) begin
         n_fail++;
         $display("FAIL packed_done: got %0d, expected %0d", done_at,
                  1 + 4 * 256);
      end
   endtask
`endif

   initial begin
      f_q = '0;
      test_reset();
      test_ramp_no_stall();
      test_stall();
      test_sign_ext_wrap();
      test_reset_abort();
      test_start_while_busy();
`ifdef FFT_WRITER_PACK_EN
      test_packed();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
